// File: rtl/dvp_rx_pkg.sv
// Shared types and constants for the DVP RX frame-write scheduler.
// The pixel path is one packed word per AXI beat.
package dvp_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_WAIT_DATA,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } sched_st_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic int beat_bytes(input int data_w);
        return data_w / 8;
    endfunction

    // Bytes per beat for the default 32-bit pixel word.
    localparam int BEAT_BYTES = beat_bytes(32);

endpackage

// File: rtl/dvp_burst_wr.sv
// Single-outstanding AXI4 write burst engine: AW, then BURST_LEN W beats, then B.
// A start pulse is only honoured while idle; done/err pulse on the B handshake.
module dvp_burst_wr
    import dvp_rx_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MST_ID_W  = 5,
    parameter int BURST_LEN = 16,
    parameter int AXI_ID    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                o_done,
    output logic                o_err,
    output sched_st_e           o_state,
    output logic [ADDR_W-1:0]   o_awaddr,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic                o_wvalid,
    input  logic                i_wready,
    output logic                o_wlast,
    output logic                o_fifo_rd,
    input  logic [MST_ID_W-1:0] i_bid,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready
);

    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    sched_st_e          r_state;
    logic [ADDR_W-1:0]  r_awaddr;
    logic               r_awvalid;
    logic               r_wvalid;
    logic               r_bready;
    logic [BEAT_W-1:0]  r_beat;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_last;

    assign w_aw_hs = r_awvalid & i_awready;
    assign w_w_hs  = r_wvalid & i_wready;
    assign w_b_hs  = r_bready & i_bvalid;
    assign w_last  = (r_beat == LAST_BEAT);

    assign o_state   = r_state;
    assign o_awaddr  = r_awaddr;
    assign o_awvalid = r_awvalid;
    assign o_wvalid  = r_wvalid;
    assign o_wlast   = r_wvalid & w_last;
    assign o_fifo_rd = w_w_hs;
    assign o_bready  = r_bready;
    assign o_done    = w_b_hs;
    assign o_err     = w_b_hs & ((i_bresp != RESP_OKAY) || (i_bid != MST_ID_W'(AXI_ID)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_awaddr  <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_beat    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_awaddr  <= i_addr;
                        r_awvalid <= 1'b1;
                        r_state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_beat    <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_w_hs) begin
                        r_beat <= r_beat + BEAT_W'(1);
                        if (w_last) begin
                            r_wvalid <= 1'b0;
                            r_bready <= 1'b1;
                            r_state  <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    // No retry on error responses: the beat data is already consumed.
                    if (w_b_hs) begin
                        r_bready <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dvp_frame_wr_sched.sv
// Frame-level write scheduler: waits for SOF, issues full bursts as the pixel FIFO
// fills, ping-pongs between two frame buffers and reports frame completion/errors.
module dvp_frame_wr_sched
    import dvp_rx_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MST_ID_W    = 5,
    parameter int BURST_LEN   = 16,
    parameter int FRAME_WORDS = 153600,
    parameter int AXI_ID      = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_en_i,
    input  logic [ADDR_W-1:0]              cfg_base0_i,
    input  logic [ADDR_W-1:0]              cfg_base1_i,
    input  logic                           sof_i,
    input  logic [$clog2(FRAME_WORDS):0]   fifo_lvl_i,
    input  logic [DATA_W-1:0]              fifo_rdata_i,
    output logic                           fifo_rd_o,
    output logic [MST_ID_W-1:0]            awid_o,
    output logic [ADDR_W-1:0]              awaddr_o,
    output logic [7:0]                     awlen_o,
    output logic                           awvalid_o,
    input  logic                           awready_i,
    output logic [DATA_W-1:0]              wdata_o,
    output logic                           wlast_o,
    output logic                           wvalid_o,
    input  logic                           wready_i,
    input  logic [MST_ID_W-1:0]            bid_i,
    input  logic [1:0]                     bresp_i,
    input  logic                           bvalid_i,
    output logic                           bready_o,
    output logic                           buf_sel_o,
    output logic                           frame_done_o,
    output logic                           err_o,
    output logic                           sof_drop_o,
    output sched_st_e                      dbg_state_o
);

    localparam int LVL_W = $clog2(FRAME_WORDS) + 1;
    localparam logic [LVL_W-1:0]  BURST_WORDS = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]  FRAME_END   = LVL_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] STRIDE      = ADDR_W'(BURST_LEN * beat_bytes(DATA_W));

    sched_st_e          r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [LVL_W-1:0]   r_words;
    logic               r_buf_sel;
    logic               r_err;
    logic               r_frame_done;
    logic               r_sof_drop;

    logic               w_start;
    logic               w_burst_done;
    logic               w_burst_err;
    logic [LVL_W-1:0]   w_words_nxt;
    sched_st_e          w_eng_state;

    assign w_start     = (r_state == ST_WAIT_DATA) && (fifo_lvl_i >= BURST_WORDS);
    assign w_words_nxt = r_words + BURST_WORDS;

    assign awid_o       = MST_ID_W'(AXI_ID);
    assign awlen_o      = 8'(BURST_LEN - 1);
    assign wdata_o      = fifo_rdata_i;
    assign buf_sel_o    = r_buf_sel;
    assign err_o        = r_err;
    assign frame_done_o = r_frame_done;
    assign sof_drop_o   = r_sof_drop;
    // ST_ADDR in r_state means "burst in flight"; the engine knows the exact phase.
    assign dbg_state_o  = (r_state == ST_ADDR) ? w_eng_state : r_state;

    dvp_burst_wr #(
        .ADDR_W    (ADDR_W),
        .MST_ID_W  (MST_ID_W),
        .BURST_LEN (BURST_LEN),
        .AXI_ID    (AXI_ID)
    ) u_burst (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_addr    (r_addr),
        .o_done    (w_burst_done),
        .o_err     (w_burst_err),
        .o_state   (w_eng_state),
        .o_awaddr  (awaddr_o),
        .o_awvalid (awvalid_o),
        .i_awready (awready_i),
        .o_wvalid  (wvalid_o),
        .i_wready  (wready_i),
        .o_wlast   (wlast_o),
        .o_fifo_rd (fifo_rd_o),
        .i_bid     (bid_i),
        .i_bresp   (bresp_i),
        .i_bvalid  (bvalid_i),
        .o_bready  (bready_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_words      <= '0;
            r_buf_sel    <= 1'b0;
            r_err        <= 1'b0;
            r_frame_done <= 1'b0;
            r_sof_drop   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            // Includes the burst-completion cycle: a frame in progress never restarts.
            r_sof_drop   <= sof_i && (r_state != ST_WAIT_SOF);
            if (w_burst_err) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (cfg_en_i) begin
                        r_state <= ST_WAIT_SOF;
                    end
                end
                ST_WAIT_SOF: begin
                    if (sof_i) begin
                        r_addr  <= r_buf_sel ? cfg_base1_i : cfg_base0_i;
                        r_words <= '0;
                        r_state <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (w_start) begin
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_burst_done) begin
                        r_addr  <= r_addr + STRIDE;
                        r_words <= w_words_nxt;
                        if (w_words_nxt == FRAME_END) begin
                            r_frame_done <= 1'b1;
                            r_buf_sel    <= ~r_buf_sel;
                            r_state      <= cfg_en_i ? ST_WAIT_SOF : ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT_DATA;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dvp_frame_wr_sched.sv
// Directed-plus-random bench for dvp_frame_wr_sched with a 64-word frame:
// a FIFO/AXI-slave model, a handshake monitor and an address/data reference model.
module tb_dvp_frame_wr_sched;
    import dvp_rx_pkg::*;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int MST_ID_W    = 5;
    localparam int BURST_LEN   = 16;
    localparam int FRAME_WORDS = 64;
    localparam int AXI_ID      = 0;
    localparam int LVL_W       = $clog2(FRAME_WORDS) + 1;
    localparam int N_BURSTS    = FRAME_WORDS / BURST_LEN;
    localparam int STRIDE      = BURST_LEN * BEAT_BYTES;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_en_i;
    logic [ADDR_W-1:0]   cfg_base0_i;
    logic [ADDR_W-1:0]   cfg_base1_i;
    logic                sof_i;
    logic [LVL_W-1:0]    fifo_lvl_i;
    logic [DATA_W-1:0]   fifo_rdata_i;
    logic                fifo_rd_o;
    logic [MST_ID_W-1:0] awid_o;
    logic [ADDR_W-1:0]   awaddr_o;
    logic [7:0]          awlen_o;
    logic                awvalid_o;
    logic                awready_i;
    logic [DATA_W-1:0]   wdata_o;
    logic                wlast_o;
    logic                wvalid_o;
    logic                wready_i;
    logic [MST_ID_W-1:0] bid_i;
    logic [1:0]          bresp_i;
    logic                bvalid_i;
    logic                bready_o;
    logic                buf_sel_o;
    logic                frame_done_o;
    logic                err_o;
    logic                sof_drop_o;
    sched_st_e           dbg_state_o;

    dvp_frame_wr_sched #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MST_ID_W(MST_ID_W),
        .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS), .AXI_ID(AXI_ID)
    ) dut (
        .clk(clk), .rst(rst), .cfg_en_i(cfg_en_i),
        .cfg_base0_i(cfg_base0_i), .cfg_base1_i(cfg_base1_i), .sof_i(sof_i),
        .fifo_lvl_i(fifo_lvl_i), .fifo_rdata_i(fifo_rdata_i), .fifo_rd_o(fifo_rd_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .buf_sel_o(buf_sel_o), .frame_done_o(frame_done_o), .err_o(err_o),
        .sof_drop_o(sof_drop_o), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    // ---------------- FIFO model ----------------
    logic [DATA_W-1:0] fifo_mem [1024];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_rdata_i = fifo_mem[rd_ptr % 1024];
    assign fifo_lvl_i   = LVL_W'(wr_ptr - rd_ptr);

    // ---------------- scoreboard state ----------------
    logic [ADDR_W-1:0] exp_aw_q[$];
    logic [DATA_W-1:0] exp_w_q[$];
    logic [ADDR_W-1:0] mon_aw_q[$];
    logic [DATA_W-1:0] mon_w_q[$];
    logic              exp_buf = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, pop_cnt = 0, fd_cnt = 0, drop_cnt = 0;
    int awlen_bad = 0, wlast_bad = 0, w_early = 0, pop_bad = 0, aw_stable_bad = 0;
    int mon_beat = 0;
    int bad_b_idx = -1;
    logic thr_en = 1'b0;
    logic flush_req = 1'b0;
    logic aw_out = 1'b0;
    logic pop_pend = 1'b0;
    logic aw_wait = 1'b0;
    logic [ADDR_W-1:0] aw_wait_addr = '0;

    // Slave responder + monitor: drive readies on negedge, sample the handshakes
    // that the next posedge will take 1 time unit later.
    always @(negedge clk) begin
        if (flush_req) begin
            rd_ptr = wr_ptr;
            pop_pend = 1'b0;
            mon_aw_q.delete();
            mon_w_q.delete();
            mon_beat = 0;
            aw_out = 1'b0;
            aw_wait = 1'b0;
        end
        if (pop_pend) begin
            rd_ptr = rd_ptr + 1;
            pop_pend = 1'b0;
        end
        awready_i = thr_en ? ($urandom_range(0, 3) == 0) : 1'b1;
        wready_i  = thr_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        bvalid_i  = bready_o && (!thr_en || ($urandom_range(0, 1) == 1));
        bresp_i   = (b_cnt == bad_b_idx) ? 2'b10 : 2'b00;
        #1;
        if (!rst && !flush_req) begin
            if (aw_wait && (!awvalid_o || awaddr_o != aw_wait_addr)) aw_stable_bad++;
            aw_wait = awvalid_o && !awready_i;
            aw_wait_addr = awaddr_o;
            if (awvalid_o && awready_i) begin
                mon_aw_q.push_back(awaddr_o);
                if (awlen_o != 8'(BURST_LEN - 1) || awid_o != MST_ID_W'(AXI_ID)) awlen_bad++;
                aw_out = 1'b1;
                aw_cnt++;
            end
            if (wvalid_o && !aw_out) w_early++;
            if (fifo_rd_o !== (wvalid_o && wready_i)) pop_bad++;
            if (wvalid_o && wready_i) begin
                mon_w_q.push_back(wdata_o);
                if (wlast_o !== ((mon_beat == BURST_LEN - 1) ? 1'b1 : 1'b0)) wlast_bad++;
                if (wlast_o) begin
                    mon_beat = 0;
                    aw_out = 1'b0;
                end else begin
                    mon_beat++;
                end
                w_cnt++;
            end
            if (fifo_rd_o) begin
                pop_cnt++;
                pop_pend = 1'b1;
            end
            if (bvalid_i && bready_o) b_cnt++;
            if (frame_done_o) fd_cnt++;
            if (sof_drop_o) drop_cnt++;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input int n);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            fifo_mem[wr_ptr % 1024] = d;
            exp_w_q.push_back(d);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    // A frame writes N_BURSTS consecutive bursts from the base of the buffer
    // selected when its SOF is accepted; buffers alternate per completed frame.
    task automatic model_frame();
        logic [ADDR_W-1:0] base;
        base = exp_buf ? cfg_base1_i : cfg_base0_i;
        for (int k = 0; k < N_BURSTS; k++) exp_aw_q.push_back(base + ADDR_W'(k * STRIDE));
        exp_buf = ~exp_buf;
    endtask

    task automatic pulse_sof();
        sof_i = 1'b1;
        @(negedge clk);
        sof_i = 1'b0;
    endtask

    task automatic check_aw(input int n);
        check("aw_count", 64'(mon_aw_q.size()), 64'(n));
        for (int i = 0; i < n; i++)
            if (mon_aw_q.size() > 0 && exp_aw_q.size() > 0)
                check("awaddr", 64'(mon_aw_q.pop_front()), 64'(exp_aw_q.pop_front()));
    endtask

    task automatic check_w(input int n);
        check("w_beats", 64'(mon_w_q.size()), 64'(n));
        for (int i = 0; i < n; i++)
            if (mon_w_q.size() > 0 && exp_w_q.size() > 0)
                check("wdata", 64'(mon_w_q.pop_front()), 64'(exp_w_q.pop_front()));
    endtask

    task automatic wait_b(input int n, input int budget);
        int cyc = 0;
        while (b_cnt < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("b_wait", 64'(b_cnt >= n), 64'(1));
    endtask

    task automatic wait_fd(input int n, input int budget);
        int cyc = 0;
        while (fd_cnt < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("frame_done_wait", 64'(fd_cnt >= n), 64'(1));
    endtask

    task automatic check_protocol();
        check("awlen_awid_bad", 64'(awlen_bad), 64'(0));
        check("wlast_bad", 64'(wlast_bad), 64'(0));
        check("w_before_aw", 64'(w_early), 64'(0));
        check("fifo_rd_bad", 64'(pop_bad), 64'(0));
        check("aw_unstable", 64'(aw_stable_bad), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int drop_base, w_base, b_base;
        rst = 1'b1;
        cfg_en_i = 1'b0;
        cfg_base0_i = '0;
        cfg_base1_i = '0;
        sof_i = 1'b0;
        bid_i = '0;
        bresp_i = 2'b00;
        bvalid_i = 1'b0;
        awready_i = 1'b0;
        wready_i = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_awvalid", 64'(awvalid_o), 64'(0));
        check("rst_wvalid", 64'(wvalid_o), 64'(0));
        check("rst_bready", 64'(bready_o), 64'(0));
        check("rst_fifo_rd", 64'(fifo_rd_o), 64'(0));
        check("rst_awaddr", 64'(awaddr_o), 64'(0));
        check("rst_buf_sel", 64'(buf_sel_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        check("rst_frame_done", 64'(frame_done_o), 64'(0));
        check("rst_sof_drop", 64'(sof_drop_o), 64'(0));
        check("rst_state", 64'(dbg_state_o), 64'(ST_IDLE));

        // Single burst from base0
        rst = 1'b0;
        cfg_en_i = 1'b1;
        cfg_base0_i = 32'h8000_0000;
        cfg_base1_i = 32'h9000_0000;
        repeat (2) @(negedge clk);
        check("state_wait_sof", 64'(dbg_state_o), 64'(ST_WAIT_SOF));
        push_words(16);
        model_frame();
        pulse_sof();
        wait_b(1, 200);
        check_aw(1);
        check_w(16);
        check("pops_burst1", 64'(pop_cnt), 64'(16));
        check_protocol();

        // Level one short of a burst holds off AW
        push_words(15);
        repeat (20) @(negedge clk);
        check("no_aw_at_15", 64'(aw_cnt), 64'(1));
        check("awvalid_at_15", 64'(awvalid_o), 64'(0));
        bad_b_idx = 1;
        push_words(1);
        check("awvalid_before_edge", 64'(awvalid_o), 64'(0));
        @(negedge clk);
        check("awvalid_next_cycle", 64'(awvalid_o), 64'(1));
        thr_en = 1'b1;

        // Burst 2 gets SLVERR; the frame still completes
        wait_b(2, 400);
        check("err_set", 64'(err_o), 64'(1));
        bad_b_idx = -1;
        push_words(32);
        w_base = 0;
        while (w_cnt <= 32 && w_base < 400) begin
            @(negedge clk);
            w_base++;
        end
        drop_base = drop_cnt;
        pulse_sof();
        check("sof_drop_pulse", 64'(sof_drop_o), 64'(1));
        @(negedge clk);
        check("sof_drop_one_clk", 64'(sof_drop_o), 64'(0));
        check("sof_drop_count", 64'(drop_cnt - drop_base), 64'(1));
        wait_fd(1, 2000);
        repeat (5) @(negedge clk);
        check("frame_done_once", 64'(fd_cnt), 64'(1));
        check("buf_sel_after_f1", 64'(buf_sel_o), 64'(exp_buf));
        check("err_sticky_f1", 64'(err_o), 64'(1));
        check("state_after_f1", 64'(dbg_state_o), 64'(ST_WAIT_SOF));
        check_aw(3);
        check_w(48);
        check("pops_f1", 64'(pop_cnt), 64'(64));

        // Second frame goes to base1 under random throttling
        push_words(64);
        model_frame();
        pulse_sof();
        wait_fd(2, 4000);
        repeat (3) @(negedge clk);
        check_aw(4);
        check_w(64);
        check("buf_sel_after_f2", 64'(buf_sel_o), 64'(exp_buf));
        check("err_sticky_f2", 64'(err_o), 64'(1));
        check("frame_done_f2", 64'(fd_cnt), 64'(2));
        check("pops_f2", 64'(pop_cnt), 64'(128));
        check_protocol();

        // Reset in the middle of a data phase
        thr_en = 1'b0;
        push_words(16);
        pulse_sof();
        w_base = w_cnt;
        b_base = 0;
        while (w_cnt < w_base + 7 && b_base < 300) begin
            @(negedge clk);
            b_base++;
        end
        check("wvalid_before_rst", 64'(wvalid_o), 64'(1));
        rst = 1'b1;
        flush_req = 1'b1;
        #1;
        check("rst_mid_awvalid", 64'(awvalid_o), 64'(0));
        check("rst_mid_wvalid", 64'(wvalid_o), 64'(0));
        check("rst_mid_fifo_rd", 64'(fifo_rd_o), 64'(0));
        check("rst_mid_state", 64'(dbg_state_o), 64'(ST_IDLE));
        check("rst_mid_err", 64'(err_o), 64'(0));
        check("rst_mid_buf_sel", 64'(buf_sel_o), 64'(0));
        exp_aw_q.delete();
        exp_w_q.delete();
        exp_buf = 1'b0;
        repeat (3) @(negedge clk);
        flush_req = 1'b0;
        rst = 1'b0;
        cfg_base0_i = $urandom & 32'hFFFF_FC00;
        repeat (2) @(negedge clk);
        b_base = b_cnt;
        push_words(16);
        model_frame();
        pulse_sof();
        wait_b(b_base + 1, 200);
        check_aw(1);
        check_w(16);
        check("state_after_rst_burst", 64'(dbg_state_o), 64'(ST_WAIT_DATA));
        check_protocol();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dvp_frame_wr_sched.md
Name: dvp_frame_wr_sched

Overview:
Schedules AXI4 write bursts that move received pixel words from the DVP RX pixel FIFO into frame memory. It tracks the frame boundaries signalled by the RX front-end and counts words per frame. It ping-pongs between two frame buffers and reports frame completion and write errors. It sits between the DVP RX pixel packer/FIFO and the AXI4 pixel-transfer master port.

Parameters:
DATA_W, 32, AXI data width (one packed pixel word per beat)
ADDR_W, 32, AXI address width
MST_ID_W, 5, AXI ID width
BURST_LEN, 16, beats per burst (1..256); FRAME_WORDS must be a multiple of it
FRAME_WORDS, 153600, words per frame (640x480 RGB565 = 614400 B / 4)
AXI_ID, 0, constant value driven on awid_o

Ports:
clk  in  1  single clock
rst  in  1  asynchronous reset, active-high
cfg_en_i  in  1  scheduler enable
cfg_base0_i  in  ADDR_W  frame buffer 0 base address (BURST-aligned)
cfg_base1_i  in  ADDR_W  frame buffer 1 base address
sof_i  in  1  start-of-frame pulse from RX (one clk)
fifo_lvl_i  in  $clog2(FRAME_WORDS)+1  words available in pixel FIFO
fifo_rdata_i  in  DATA_W  FIFO head word (first-word-fall-through)
fifo_rd_o  out  1  FIFO pop
awid_o  out  MST_ID_W  AW id (= AXI_ID)
awaddr_o  out  ADDR_W  burst address
awlen_o  out  8  BURST_LEN-1
awvalid_o  out  1  AW valid
awready_i  in  1  AW ready
wdata_o  out  DATA_W  write data (= fifo_rdata_i)
wlast_o  out  1  last beat
wvalid_o  out  1  W valid
wready_i  in  1  W ready
bid_i  in  MST_ID_W  response id
bresp_i  in  2  response code
bvalid_i  in  1  B valid
bready_o  out  1  B ready
buf_sel_o  out  1  buffer currently being written
frame_done_o  out  1  one-clk pulse: frame fully written and acknowledged
err_o  out  1  sticky: non-OKAY bresp or unexpected bid
sof_drop_o  out  1  one-clk pulse: sof_i ignored mid-frame

Behaviour:
- Reset (async, immediate): state IDLE; all valid/ready/pulse outputs 0; awaddr_o 0; buf_sel_o 0; err_o 0; word and beat counters 0. Any in-flight burst is abandoned.
- States: IDLE, WAIT_SOF, WAIT_DATA, ADDR, DATA, RESP.
- IDLE -> WAIT_SOF when cfg_en_i=1.
- WAIT_SOF -> WAIT_DATA on sof_i. In the same cycle: latch base = buf_sel_o ? cfg_base1_i : cfg_base0_i into the address register; clear the word counter.
- WAIT_DATA -> ADDR when fifo_lvl_i >= BURST_LEN. Full bursts only; no partial bursts.
- ADDR: awvalid_o=1 and held stable until awready_i. On the handshake go to DATA; awvalid_o drops the next cycle.
- DATA: wvalid_o=1, wdata_o=fifo_rdata_i, fifo_rd_o = wvalid_o & wready_i (combinational). The beat counter increments per handshake. wlast_o=1 when beat counter = BURST_LEN-1. Handshake with wlast -> RESP. wvalid_o never asserted before the AW handshake.
- RESP: bready_o=1. On bvalid_i, err_o is set if bresp_i != 0 or bid_i != AXI_ID; no retry. After the handshake:
  - awaddr advances by BURST_LEN*DATA_W/8;
  - word counter advances by BURST_LEN;
  - if word counter reaches FRAME_WORDS: pulse frame_done_o, toggle buf_sel_o, then go to WAIT_SOF if cfg_en_i else IDLE;
  - otherwise go to WAIT_DATA.
- Only one outstanding burst at a time.
- Address arithmetic is modulo 2^ADDR_W; no 4 KB check (bases must be aligned so bursts never cross 4 KB).
- sof_i in any state other than WAIT_SOF: ignored, sof_drop_o pulsed. The frame continues to its word count.
- cfg_en_i deassert mid-frame: the current frame completes, then IDLE.
- cfg_base changes take effect only at the next sof latch.
- sof_i and frame_done in the same cycle (RESP exit): the sof is dropped (sof_drop_o=1).

Decomposition:
- Package dvp_rx_pkg: state enum sched_st_e, AXI response constants (RESP_OKAY=2'b00), and localparam BEAT_BYTES = DATA_W/8.
- Sub-module dvp_burst_wr: the ADDR/DATA/RESP AXI burst engine, with start/addr inputs and done/err outputs. The frame/buffer sequencing stays in the top.

Test Plan:
- Reset then cfg_en_i=1, base0=0x8000_0000, sof_i, fifo_lvl_i=16 -> one burst: awaddr_o=0x8000_0000, awlen_o=15, 16 W beats, wlast_o on beat 16, 16 fifo_rd_o pulses.
- FRAME_WORDS=64 (override), full frame with awready_i/wready_i randomly throttled -> 4 bursts at base+0x0/0x40/0x80/0xC0, frame_done_o once, buf_sel_o 0->1. Next sof writes at base1.
- fifo_lvl_i held at 15 -> no awvalid_o. Raising it to 16 -> awvalid_o on the next cycle.
- bresp_i=2'b10 on burst 2 -> err_o=1 and stays set. The frame still completes with frame_done_o.
- sof_i pulsed during DATA -> sof_drop_o=1 for one clk; addresses and counts unchanged.
- rst asserted mid-DATA (after beat 7) -> awvalid_o/wvalid_o/fifo_rd_o go to 0 immediately and state returns to IDLE. After release, the next frame starts at base0.
